// File: rtl/user_bitrev_acc.sv
// Multi-channel bit/byte/nibble/halfword reversal accelerator behind an OBI subordinate port.
// Each channel reverses its DATA word into RESULT one BitsPerCycle-wide slice per cycle.

package user_bitrev_acc_pkg;

  localparam int unsigned SbrIdW = 4;

  typedef struct packed {
    int unsigned DataWidth;
    int unsigned AddrWidth;
  } obi_cfg_t;

  localparam obi_cfg_t SbrObiCfg = '{DataWidth: 32, AddrWidth: 32};

  typedef struct packed {
    logic [31:0]       addr;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [SbrIdW-1:0] aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    sbr_obi_a_chan_t a;
    logic            req;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0]       rdata;
    logic [SbrIdW-1:0] rid;
    logic              err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

endpackage

module user_bitrev_acc
  import user_bitrev_acc_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg       = SbrObiCfg,
  parameter type         obi_req_t    = sbr_obi_req_t,
  parameter type         obi_rsp_t    = sbr_obi_rsp_t,
  parameter int unsigned NumChannels  = 2,
  parameter int unsigned BitsPerCycle = 8
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output logic     irq_o
);

  localparam int unsigned DataW     = 32;
  localparam int unsigned IdW       = $bits(obi_req_i.a.aid);
  localparam int unsigned NumSlices = DataW / BitsPerCycle;
  localparam int unsigned CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam logic [CntW-1:0] LastCnt   = CntW'(NumSlices - 1);
  localparam logic [31:0]     SliceMask = 32'((64'd1 << BitsPerCycle) - 64'd1);
  localparam logic [8:0]      RangeEnd  = 9'(NumChannels * 16);

  // Reject illegal configurations at elaboration.
  if (ObiCfg.DataWidth != 32 || ObiCfg.AddrWidth != 32) begin : g_bad_cfg
    $fatal(1, "user_bitrev_acc: OBI data and address width must be 32");
  end
  if (!(BitsPerCycle == 1 || BitsPerCycle == 2 || BitsPerCycle == 4 ||
        BitsPerCycle == 8 || BitsPerCycle == 16 || BitsPerCycle == 32)) begin : g_bad_bpc
    $fatal(1, "user_bitrev_acc: BitsPerCycle must be 1, 2, 4, 8, 16 or 32");
  end
  if (NumChannels < 1 || NumChannels > 8) begin : g_bad_nch
    $fatal(1, "user_bitrev_acc: NumChannels must be 1..8");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Request decode
  logic [7:0] off;
  logic [3:0] ch_sel;
  logic [1:0] reg_sel;
  logic       acc, we, in_range;
  logic       unused_addr;

  assign off         = obi_req_i.a.addr[7:0];
  assign ch_sel      = off[7:4];
  assign reg_sel     = off[3:2];
  assign acc         = obi_req_i.req;
  assign we          = obi_req_i.a.we;
  assign in_range    = ({1'b0, off} < RangeEnd);
  assign unused_addr = ^{obi_req_i.a.addr[31:8], obi_req_i.a.addr[1:0]};

  // Channel state
  logic [NumChannels-1:0][31:0]     data_q, data_d, work_q, work_d, result_q, result_d;
  logic [NumChannels-1:0][1:0]      mode_q, mode_d, wmode_q, wmode_d;
  logic [NumChannels-1:0]           irq_en_q, irq_en_d, done_q, done_d;
  logic [NumChannels-1:0][CntW-1:0] cnt_q, cnt_d;
  state_e                           state_q [NumChannels];
  state_e                           state_d [NumChannels];

  // Per-channel helpers
  logic [NumChannels-1:0]       sel, start;
  logic [NumChannels-1:0][31:0] slice_mask, mode_res;

  // Response registers
  logic           rvalid_q, rvalid_d, err_q, err_d, irq_q, irq_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [IdW-1:0] rid_q, rid_d;

  // Reversal function selected by mode.
  function automatic logic [31:0] mode_fn(input logic [1:0] mode, input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    case (mode)
      2'd0:    for (int i = 0; i < 32; i++) r[i] = w[31-i];
      2'd1:    r = {w[7:0], w[15:8], w[23:16], w[31:24]};
      2'd2:    for (int i = 0; i < 8; i++) r[4*i +: 4] = w[4*(7-i) +: 4];
      default: r = {w[15:0], w[31:16]};
    endcase
    return r;
  endfunction

  // Channel select, start strobe, current slice mask and reversed word.
  always_comb begin
    sel        = '0;
    start      = '0;
    slice_mask = '0;
    mode_res   = '0;
    for (int c = 0; c < NumChannels; c++) begin
      sel[c]        = acc & in_range & (ch_sel == 4'(c));
      start[c]      = sel[c] & we & (reg_sel == 2'd1) & obi_req_i.a.be[0] & obi_req_i.a.wdata[0];
      slice_mask[c] = SliceMask << (5'(cnt_q[c]) * 5'(BitsPerCycle));
      mode_res[c]   = mode_fn(wmode_q[c], work_q[c]);
    end
  end

  // Next-state: register writes, read mux, channel FSMs, interrupt.
  always_comb begin
    data_d   = data_q;
    work_d   = work_q;
    result_d = result_q;
    mode_d   = mode_q;
    wmode_d  = wmode_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    for (int c = 0; c < NumChannels; c++) state_d[c] = state_q[c];
    rvalid_d = acc;
    rid_d    = obi_req_i.a.aid;
    err_d    = acc & ~in_range;
    rdata_d  = '0;

    for (int c = 0; c < NumChannels; c++) begin
      if (sel[c] && !we) begin
        case (reg_sel)
          2'd0:    rdata_d = data_q[c];
          2'd1:    rdata_d = {28'd0, irq_en_q[c], mode_q[c], 1'b0};
          2'd2:    rdata_d = {30'd0, done_q[c], (state_q[c] == StRun)};
          default: rdata_d = result_q[c];
        endcase
      end

      if (sel[c] && we && reg_sel == 2'd0) begin
        for (int b = 0; b < 4; b++) begin
          if (obi_req_i.a.be[b]) data_d[c][8*b +: 8] = obi_req_i.a.wdata[8*b +: 8];
        end
      end
      if (sel[c] && we && reg_sel == 2'd1 && obi_req_i.a.be[0]) begin
        mode_d[c]   = obi_req_i.a.wdata[2:1];
        irq_en_d[c] = obi_req_i.a.wdata[3];
      end

      // Status read clears done; a same-cycle completion below overrides it.
      if (sel[c] && !we && reg_sel == 2'd2) done_d[c] = 1'b0;

      case (state_q[c])
        StIdle, StDone: begin
          if (start[c]) begin
            state_d[c] = StRun;
            work_d[c]  = data_q[c];
            wmode_d[c] = obi_req_i.a.wdata[2:1];
            done_d[c]  = 1'b0;
            cnt_d[c]   = '0;
          end
        end
        StRun: begin
          result_d[c] = (result_q[c] & ~slice_mask[c]) | (mode_res[c] & slice_mask[c]);
          if (cnt_q[c] == LastCnt) begin
            state_d[c] = StDone;
            done_d[c]  = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + CntW'(1);
          end
        end
        default: state_d[c] = StIdle;
      endcase
    end

    irq_d = |(done_d & irq_en_d);
  end

  // State and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q   <= '0;
      work_q   <= '0;
      result_q <= '0;
      mode_q   <= '0;
      wmode_q  <= '0;
      irq_en_q <= '0;
      done_q   <= '0;
      cnt_q    <= '0;
      for (int c = 0; c < NumChannels; c++) state_q[c] <= StIdle;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      work_q   <= work_d;
      result_q <= result_d;
      mode_q   <= mode_d;
      wmode_q  <= wmode_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      for (int c = 0; c < NumChannels; c++) state_q[c] <= state_d[c];
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rid_q    <= rid_d;
      irq_q    <= irq_d;
    end
  end

  // Grant follows request directly; everything else comes from registers.
  always_comb begin
    obi_rsp_o         = '0;
    obi_rsp_o.gnt     = obi_req_i.req;
    obi_rsp_o.rvalid  = rvalid_q;
    obi_rsp_o.r.rdata = rdata_q;
    obi_rsp_o.r.rid   = rid_q;
    obi_rsp_o.r.err   = err_q;
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_user_bitrev_acc.sv
// Scoreboard bench for user_bitrev_acc (2 channels, 8 bits per cycle).
module tb_user_bitrev_acc;
  import user_bitrev_acc_pkg::*;

  logic         clk = 1'b0;
  logic         rst_ni;
  sbr_obi_req_t req;
  sbr_obi_rsp_t rsp;
  logic         irq;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  rid;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] aid_ctr  = '0;

  always #5 clk = ~clk;

  user_bitrev_acc #(
    .ObiCfg      (SbrObiCfg),
    .obi_req_t   (sbr_obi_req_t),
    .obi_rsp_t   (sbr_obi_rsp_t),
    .NumChannels (2),
    .BitsPerCycle(8)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .obi_req_i(req),
    .obi_rsp_o(rsp),
    .irq_o    (irq)
  );

  // Reference reversal, written independently with streaming operators.
  function automatic logic [31:0] ref_fn(input logic [1:0] mode, input logic [31:0] w);
    case (mode)
      2'd0:    return {<<{w}};
      2'd1:    return {<<8{w}};
      2'd2:    return {<<4{w}};
      default: return {w[15:0], w[31:16]};
    endcase
  endfunction

  // Drive one request for one cycle and queue its expected response.
  task automatic xfer(input logic [31:0] addr, input logic w, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    @(negedge clk);
    req.req     = 1'b1;
    req.a.addr  = addr;
    req.a.we    = w;
    req.a.wdata = wdata;
    req.a.be    = be;
    req.a.aid   = aid_ctr;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.rid   = aid_ctr;
    exp_q.push_back(e);
    aid_ctr = aid_ctr + 4'd1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req.req = 1'b0;
    end
  endtask

  // Response monitor: every rvalid pops and checks the oldest expectation.
  always @(negedge clk) begin
    if (rst_ni && rsp.rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rvalid rdata=%h err=%b rid=%0d", rsp.r.rdata, rsp.r.err, rsp.r.rid);
      end else begin
        mon_e = exp_q.pop_front();
        if (rsp.r.rdata !== mon_e.rdata || rsp.r.err !== mon_e.err || rsp.r.rid !== mon_e.rid) begin
          failures++;
          $display("FAIL rsp got rdata=%h err=%b rid=%0d expected rdata=%h err=%b rid=%0d",
                   rsp.r.rdata, rsp.r.err, rsp.r.rid, mon_e.rdata, mon_e.err, mon_e.rid);
        end
      end
    end
  end

  task automatic test_reset();
    req    = '0;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    checks++;
    if (rsp.rvalid !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got rvalid=%b irq=%b expected 0 0", rsp.rvalid, irq);
    end
    xfer(32'h00, 1'b0, '0, 4'hF, 32'h0, 1'b0);
    xfer(32'h04, 1'b0, '0, 4'hF, 32'h0, 1'b0);
    xfer(32'h08, 1'b0, '0, 4'hF, 32'h0, 1'b0);
    xfer(32'h0C, 1'b0, '0, 4'hF, 32'h0, 1'b0);
    xfer(32'h1C, 1'b0, '0, 4'hF, 32'h0, 1'b0);
    idle(2);
  endtask

  task automatic test_byte_lanes();
    xfer(32'h00, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);
    xfer(32'h00, 1'b1, 32'h1122_3344, 4'h5, 32'h0, 1'b0);
    xfer(32'h00, 1'b0, '0, 4'hF, 32'hFF22_FF44, 1'b0);
    xfer(32'h04, 1'b1, 32'h0000_000E, 4'hE, 32'h0, 1'b0);
    xfer(32'h04, 1'b0, '0, 4'hF, 32'h0, 1'b0);
    xfer(32'h08, 1'b1, 32'h3, 4'hF, 32'h0, 1'b0);
    xfer(32'h0C, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    xfer(32'h08, 1'b0, '0, 4'hF, 32'h0, 1'b0);
    xfer(32'h0C, 1'b0, '0, 4'hF, 32'h0, 1'b0);
    idle(2);
  endtask

  task automatic test_basic();
    xfer(32'h00, 1'b1, 32'h0000_0001, 4'hF, 32'h0, 1'b0);
    xfer(32'h04, 1'b1, 32'h1, 4'hF, 32'h0, 1'b0);
    xfer(32'h08, 1'b0, '0, 4'hF, 32'h1, 1'b0);           // busy
    idle(6);
    xfer(32'h08, 1'b0, '0, 4'hF, 32'h2, 1'b0);           // done
    xfer(32'h0C, 1'b0, '0, 4'hF, 32'h8000_0000, 1'b0);
    xfer(32'h08, 1'b0, '0, 4'hF, 32'h0, 1'b0);           // cleared by previous read
    xfer(32'h04, 1'b0, '0, 4'hF, 32'h0, 1'b0);           // start reads back 0
    idle(2);
  endtask

  task automatic test_modes();
    logic [31:0] dv [7];
    logic [1:0]  mv [7];
    logic [31:0] ev [7];
    dv[0] = 32'h1122_3344; mv[0] = 2'd1; ev[0] = 32'h4433_2211;
    dv[1] = 32'h1234_5678; mv[1] = 2'd2; ev[1] = 32'h8765_4321;
    dv[2] = 32'hAAAA_5555; mv[2] = 2'd3; ev[2] = 32'h5555_AAAA;
    for (int i = 3; i < 7; i++) begin
      dv[i] = $urandom;
      mv[i] = 2'(i - 3);
      ev[i] = ref_fn(mv[i], dv[i]);
    end
    for (int i = 0; i < 7; i++) begin
      xfer(32'h10, 1'b1, dv[i], 4'hF, 32'h0, 1'b0);
      xfer(32'h14, 1'b1, {29'd0, mv[i], 1'b1}, 4'hF, 32'h0, 1'b0);
      idle(6);
      xfer(32'h1C, 1'b0, '0, 4'hF, ev[i], 1'b0);
      xfer(32'h18, 1'b0, '0, 4'hF, 32'h2, 1'b0);
    end
    idle(2);
  endtask

  task automatic test_irq_latency();
    int lat;
    lat = 0;
    xfer(32'h10, 1'b1, 32'hF0F0_F0F0, 4'hF, 32'h0, 1'b0);
    xfer(32'h14, 1'b1, 32'h9, 4'hF, 32'h0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      req.req = 1'b0;
      if (irq === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != 5) begin
      failures++;
      $display("FAIL irq_latency got %0d cycles expected 5 (0 = timeout)", lat);
    end
    xfer(32'h1C, 1'b0, '0, 4'hF, 32'h0F0F_0F0F, 1'b0);
    xfer(32'h18, 1'b0, '0, 4'hF, 32'h2, 1'b0);
    @(negedge clk);
    req.req = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_clear got irq=%b expected 0", irq);
    end
    xfer(32'h18, 1'b0, '0, 4'hF, 32'h0, 1'b0);
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] da, db;
    da = 32'h0000_ABCD;
    db = 32'h1122_3344;
    xfer(32'h00, 1'b1, da, 4'hF, 32'h0, 1'b0);
    xfer(32'h10, 1'b1, db, 4'hF, 32'h0, 1'b0);
    xfer(32'h04, 1'b1, 32'h1, 4'hF, 32'h0, 1'b0);
    xfer(32'h14, 1'b1, 32'h3, 4'hF, 32'h0, 1'b0);
    xfer(32'h00, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);  // DATA update mid-run
    xfer(32'h04, 1'b1, 32'h1, 4'hF, 32'h0, 1'b0);          // ignored restart
    xfer(32'h08, 1'b0, '0, 4'hF, 32'h1, 1'b0);
    idle(8);
    xfer(32'h0C, 1'b0, '0, 4'hF, ref_fn(2'd0, da), 1'b0);
    xfer(32'h1C, 1'b0, '0, 4'hF, 32'h4433_2211, 1'b0);
    xfer(32'h00, 1'b0, '0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    xfer(32'h08, 1'b0, '0, 4'hF, 32'h2, 1'b0);
    xfer(32'h18, 1'b0, '0, 4'hF, 32'h2, 1'b0);
    idle(2);
  endtask

  task automatic test_error_and_reset();
    xfer(32'h20, 1'b0, '0, 4'hF, 32'h0, 1'b1);
    #1;
    checks++;
    if (rsp.gnt !== 1'b1) begin
      failures++;
      $display("FAIL gnt got %b expected 1", rsp.gnt);
    end
    xfer(32'h20, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    xfer(32'h3C, 1'b0, '0, 4'hF, 32'h0, 1'b1);
    xfer(32'h00, 1'b0, '0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    xfer(32'h00, 1'b1, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
    xfer(32'h04, 1'b1, 32'h9, 4'hF, 32'h0, 1'b0);
    idle(2);
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    checks++;
    if (rsp.rvalid !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got rvalid=%b irq=%b expected 0 0", rsp.rvalid, irq);
    end
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    xfer(32'h00, 1'b0, '0, 4'hF, 32'h0, 1'b0);
    xfer(32'h04, 1'b0, '0, 4'hF, 32'h0, 1'b0);
    xfer(32'h08, 1'b0, '0, 4'hF, 32'h0, 1'b0);
    xfer(32'h0C, 1'b0, '0, 4'hF, 32'h0, 1'b0);
    xfer(32'h10, 1'b0, '0, 4'hF, 32'h0, 1'b0);
    xfer(32'h1C, 1'b0, '0, 4'hF, 32'h0, 1'b0);
    idle(8);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_after_reset got %b expected 0", irq);
    end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_basic();
    test_modes();
    test_irq_latency();
    test_back_to_back();
    test_error_and_reset();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_responses got %0d outstanding expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/user_bitrev_acc.md
USER_BITREV_ACC -- requirements
Module: user_bitrev_acc

Interface
REQ-001 SHALL have parameter ObiCfg, default SbrObiCfg, OBI subordinate configuration (DataWidth=32, AddrWidth=32).
REQ-002 SHALL have parameter obi_req_t, default sbr_obi_req_t, OBI request struct type.
REQ-003 SHALL have parameter obi_rsp_t, default sbr_obi_rsp_t, OBI response struct type.
REQ-004 SHALL have parameter NumChannels, default 2, number of independent reversal channels (range 1..8).
REQ-005 SHALL have parameter BitsPerCycle, default 8, output bits produced per cycle; legal values 1, 2, 4, 8, 16, 32; any other value SHALL fail elaboration.
REQ-006 SHALL have port clk_i, input, 1, the single clock.
REQ-007 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port obi_req_i, input, obi_req_t, OBI request (a.addr, a.we, a.be, a.wdata, a.aid, req).
REQ-009 SHALL have port obi_rsp_o, output, obi_rsp_t, OBI response (gnt, rvalid, r.rdata, r.rid, r.err).
REQ-010 SHALL have port irq_o, output, 1, level interrupt, OR of all channels' (done & irq_en).

Function
REQ-011 SHALL assert gnt combinationally equal to req; SHALL keep at most one transaction outstanding.
REQ-012 SHALL assert rvalid exactly one cycle after each granted request, with rid equal to the registered aid.
REQ-013 SHALL decode per-channel registers at offset ch*0x10 using addr[7:0]: 0x0 DATA (RW), 0x4 CTRL (RW), 0x8 STATUS (RO), 0xC RESULT (RO).
REQ-014 SHALL return err=1 and rdata=0 for offsets >= NumChannels*0x10; such writes SHALL have no effect.
REQ-015 SHALL apply writes to DATA per byte lane according to be; CTRL writes SHALL use byte 0 only.
REQ-016 CTRL SHALL contain start at bit 0 (write-1 pulse, reads 0), mode at bits [2:1], and irq_en at bit 3.
REQ-017 Mode encodings SHALL be: 0 = full bit reverse, 1 = byte reverse, 2 = nibble reverse, 3 = halfword swap.
REQ-018 STATUS SHALL contain busy at bit 0 and done at bit 1; all other bits SHALL read 0.
REQ-019 Writes to STATUS or RESULT SHALL be ignored and answered with err=0.
REQ-020 Each channel SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-021 From IDLE or DONE, a start write SHALL capture DATA into a working register, clear done, clear the slice counter and enter RUN on the next cycle.
REQ-022 In RUN, each cycle SHALL write output slice k (BitsPerCycle bits, k = 0..32/BitsPerCycle-1) of RESULT from the mode function of the working register, then increment k.
REQ-023 After the last slice is written, the channel SHALL enter DONE and set done.
REQ-024 Latency from the start-write grant cycle to done=1 SHALL be 32/BitsPerCycle+1 cycles for every mode.
REQ-025 A start write while in RUN SHALL be ignored; a DATA write while in RUN SHALL update DATA without affecting the ongoing operation.
REQ-026 Reading STATUS SHALL clear done after returning its pre-clear value; if done sets in the same cycle, set SHALL win.
REQ-027 RESULT SHALL hold its previous value until overwritten slice-by-slice by a new operation.
REQ-028 Channels SHALL operate concurrently and independently; a start to one channel SHALL NOT affect any other channel.

Reset
REQ-029 On rst_ni low, all channels SHALL asynchronously go to IDLE, and DATA, CTRL, RESULT, busy, done, counters, rvalid, rdata, err and irq_o SHALL become 0.
REQ-030 A reset asserted during RUN SHALL abort the operation; after release, RESULT=0 and busy=0.

Verification
REQ-031 With BitsPerCycle=8: write ch0 DATA=0x00000001, then CTRL=0x1 -> busy for 4 RUN cycles, then RESULT=0x80000000 and done=1.
REQ-032 Mode checks: DATA=0x11223344 with mode 1 -> RESULT=0x44332211; DATA=0x12345678 with mode 2 -> 0x87654321; DATA=0xAAAA5555 with mode 3 -> 0x5555AAAA.
REQ-033 Interrupt: CTRL=0x9 on ch1 -> irq_o=1 at completion; a STATUS read returns 0x2, then irq_o=0 and STATUS reads 0x0.
REQ-034 Concurrency and protection: start ch0 and ch1 back-to-back, then re-start ch0 mid-RUN with new DATA -> both results correct, and ch0 result reflects the original DATA.
REQ-035 Error and reset: access offset NumChannels*0x10 -> err=1, rdata=0; assert rst_ni mid-RUN -> all registers and irq_o are 0 after release.
